// File: rtl/shared_reg_mailbox.sv
// ---------------------------------------------------------------------------
// shared_reg_mailbox
//
// Peripheral-side endpoint of the processor's shared-register window.
// The processor writes arguments into reg17..reg25 and a command word into
// reg26, then rings the doorbell by changing reg26[31:24] (seq) so that it
// differs from the ack_seq field of reg27. The mailbox snapshots the
// command, streams it to an external engine as header + argument beats,
// waits for the engine's response and publishes status/results in
// reg27..reg29.
//
// Ports:
//   clock            single clock domain
//   ctrl_reset       synchronous reset, active-low
//   reg17..reg25     argument words (argument k is reg(16+k))
//   reg26            command: [31:24] seq, [23:16] opcode, [3:0] arg_count
//   reg27            status: [31:24] ack_seq, [23:16] opcode echo,
//                    [3] bad_count, [2] timeout, [1] error, [0] busy
//   reg28, reg29     result0, result1
//   cmd_valid/ready  command beat handshake
//   cmd_data         beat payload
//   cmd_index        0 = header (reg26 snapshot), 1..9 = argument
//   cmd_last         final beat of the command
//   rsp_valid/ready  response handshake (rsp_ready high only in WAIT)
//   rsp_data0/1      response words
//   rsp_error        engine error flag
//
// Optional feature: define SHARED_REG_MAILBOX_TIMEOUT_EN to abort a WAIT
// that lasts TIMEOUT_CYCLES cycles without a response (timeout = 1,
// results forced to 0). Without it WAIT holds until a response arrives.
// ---------------------------------------------------------------------------
module shared_reg_mailbox #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_ARGS       = 9
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic [31:0] reg17,
  input  logic [31:0] reg18,
  input  logic [31:0] reg19,
  input  logic [31:0] reg20,
  input  logic [31:0] reg21,
  input  logic [31:0] reg22,
  input  logic [31:0] reg23,
  input  logic [31:0] reg24,
  input  logic [31:0] reg25,
  input  logic [31:0] reg26,
  output logic [31:0] reg27,
  output logic [31:0] reg28,
  output logic [31:0] reg29,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic [3:0]  cmd_index,
  output logic        cmd_last,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_data0,
  input  logic [31:0] rsp_data1,
  input  logic        rsp_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [3:0] MAX_ARGS_C = 4'(MAX_ARGS);

  logic [1:0]  state_r;
  logic [7:0]  snap_seq_r;
  logic [7:0]  snap_op_r;
  logic [3:0]  snap_cnt_r;
  logic [31:0] args_r [1:9];

  logic [31:0] reg27_r;
  logic [31:0] reg28_r;
  logic [31:0] reg29_r;
  logic        cmd_valid_r;
  logic [31:0] cmd_data_r;
  logic [3:0]  cmd_index_r;
  logic        cmd_last_r;
  logic        rsp_ready_r;

  logic        doorbell_s;
  logic        bad_count_s;
  logic        beat_s;
  logic        accept_s;
  logic        timeout_s;
  logic [3:0]  next_idx_s;

  // Doorbell compares against the published ack_seq, so a command is only
  // picked up while idle and an acknowledged seq never re-fires.
  assign doorbell_s  = (state_r == ST_IDLE) && (reg26[31:24] != reg27_r[31:24]);
  assign bad_count_s = (reg26[3:0] == 4'd0) || (reg26[3:0] > MAX_ARGS_C);
  assign beat_s      = cmd_valid_r && cmd_ready;
  assign accept_s    = rsp_ready_r && rsp_valid;
  assign next_idx_s  = cmd_index_r + 4'd1;

`ifdef SHARED_REG_MAILBOX_TIMEOUT_EN
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMEOUT_W-1:0] wait_cnt_r;

  // Cycles spent in WAIT; held at zero elsewhere so it is clear on entry.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      wait_cnt_r <= {TIMEOUT_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wait_cnt_r <= {TIMEOUT_W{1'b0}};
    end else begin
      wait_cnt_r <= wait_cnt_r + TIMEOUT_W'(1);
    end
  end

  // Fires on the edge where the count would reach TIMEOUT_CYCLES.
  assign timeout_s = (state_r == ST_WAIT) &&
                     (wait_cnt_r == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  // Never true for a legal TIMEOUT_CYCLES; WAIT holds until a response.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // Mailbox sequencer: snapshot, beat streaming, response capture.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_r     <= ST_IDLE;
      snap_seq_r  <= 8'h00;
      snap_op_r   <= 8'h00;
      snap_cnt_r  <= 4'd0;
      for (int k = 1; k <= 9; k++) begin
        args_r[k] <= 32'h0000_0000;
      end
      reg27_r     <= 32'h0000_0000;
      reg28_r     <= 32'h0000_0000;
      reg29_r     <= 32'h0000_0000;
      cmd_valid_r <= 1'b0;
      cmd_data_r  <= 32'h0000_0000;
      cmd_index_r <= 4'd0;
      cmd_last_r  <= 1'b0;
      rsp_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (doorbell_s) begin
            snap_seq_r <= reg26[31:24];
            snap_op_r  <= reg26[23:16];
            snap_cnt_r <= reg26[3:0];
            args_r[1]  <= reg17;
            args_r[2]  <= reg18;
            args_r[3]  <= reg19;
            args_r[4]  <= reg20;
            args_r[5]  <= reg21;
            args_r[6]  <= reg22;
            args_r[7]  <= reg23;
            args_r[8]  <= reg24;
            args_r[9]  <= reg25;
            if (bad_count_s) begin
              // Rejected without any beats; results keep their old values.
              reg27_r <= {reg26[31:16], 12'h000, 4'b1000};
            end else begin
              // ack_seq is left alone while busy so the doorbell stays
              // meaningful to the processor until completion.
              reg27_r     <= {reg27_r[31:16], 12'h000, 4'b0001};
              state_r     <= ST_SEND;
              cmd_valid_r <= 1'b1;
              cmd_data_r  <= reg26;
              cmd_index_r <= 4'd0;
              cmd_last_r  <= 1'b0;
            end
          end
        end
        ST_SEND: begin
          if (beat_s) begin
            if (cmd_last_r) begin
              cmd_valid_r <= 1'b0;
              cmd_last_r  <= 1'b0;
              rsp_ready_r <= 1'b1;
              state_r     <= ST_WAIT;
            end else begin
              cmd_index_r <= next_idx_s;
              cmd_data_r  <= args_r[next_idx_s];
              cmd_last_r  <= (next_idx_s == snap_cnt_r);
            end
          end
        end
        ST_WAIT: begin
          // A response on the same edge as the timeout takes priority.
          if (accept_s) begin
            reg27_r     <= {snap_seq_r, snap_op_r, 12'h000, 1'b0, 1'b0, rsp_error, 1'b0};
            reg28_r     <= rsp_data0;
            reg29_r     <= rsp_data1;
            rsp_ready_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (timeout_s) begin
            reg27_r     <= {snap_seq_r, snap_op_r, 12'h000, 4'b0100};
            reg28_r     <= 32'h0000_0000;
            reg29_r     <= 32'h0000_0000;
            rsp_ready_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_valid_r <= 1'b0;
          cmd_last_r  <= 1'b0;
          rsp_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign reg27     = reg27_r;
  assign reg28     = reg28_r;
  assign reg29     = reg29_r;
  assign cmd_valid = cmd_valid_r;
  assign cmd_data  = cmd_data_r;
  assign cmd_index = cmd_index_r;
  assign cmd_last  = cmd_last_r;
  assign rsp_ready = rsp_ready_r;

endmodule

// File: tb/tb_shared_reg_mailbox.sv
// ---------------------------------------------------------------------------
// tb_shared_reg_mailbox
//
// Directed bench for shared_reg_mailbox: normal command, stalled beats,
// seq changes while busy, bad arg_count, reset mid-command with a 9-arg
// command, and WAIT behaviour with and without
// SHARED_REG_MAILBOX_TIMEOUT_EN (TIMEOUT_CYCLES = 8 here).
// ---------------------------------------------------------------------------
module tb_shared_reg_mailbox;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic [31:0] reg17, reg18, reg19, reg20, reg21, reg22, reg23, reg24, reg25, reg26;
  logic [31:0] reg27, reg28, reg29;
  logic        cmd_valid, cmd_ready, cmd_last;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_index;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_data0, rsp_data1;

  int checks_r = 0;
  int errors_r = 0;
  logic [31:0] exp_data [0:9];

  shared_reg_mailbox #(.TIMEOUT_CYCLES(8), .MAX_ARGS(9)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .reg17(reg17), .reg18(reg18), .reg19(reg19), .reg20(reg20), .reg21(reg21),
    .reg22(reg22), .reg23(reg23), .reg24(reg24), .reg25(reg25), .reg26(reg26),
    .reg27(reg27), .reg28(reg28), .reg29(reg29),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_index(cmd_index), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(rsp_data0),
    .rsp_data1(rsp_data1), .rsp_error(rsp_error)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive cmd_ready from a repeating pattern and check every beat against
  // exp_data; also checks that stalled beats hold their payload.
  task automatic collect(input int n_beats, input logic [7:0] rpat);
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held_d = 32'h0;
    logic [3:0]  held_i = 4'd0;
    while (got < n_beats && cyc < 64) begin
      cmd_ready = rpat[cyc % 8];
      if (cmd_valid) begin
        check_eq("busy_in_send", {31'h0, reg27[0]}, 32'h1);
        if (stalled) begin
          check_eq("stall_data", cmd_data, held_d);
          check_eq("stall_index", {28'h0, cmd_index}, {28'h0, held_i});
        end
        if (cmd_ready) begin
          check_eq("beat_index", {28'h0, cmd_index}, got);
          check_eq("beat_data", cmd_data, exp_data[got]);
          check_eq("beat_last", {31'h0, cmd_last}, (got == n_beats - 1) ? 32'h1 : 32'h0);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = cmd_data;
          held_i  = cmd_index;
        end
      end
      tick();
      cyc++;
    end
    cmd_ready = 1'b0;
    check_eq("beat_count", got, n_beats);
    check_eq("wait_valid_low", {31'h0, cmd_valid}, 32'h0);
    check_eq("wait_rsp_ready", {31'h0, rsp_ready}, 32'h1);
  endtask

  task automatic respond(input logic [31:0] d0, input logic [31:0] d1, input logic err);
    rsp_valid = 1'b1;
    rsp_data0 = d0;
    rsp_data1 = d1;
    rsp_error = err;
    tick();
    rsp_valid = 1'b0;
    rsp_data0 = 32'h0;
    rsp_data1 = 32'h0;
    rsp_error = 1'b0;
  endtask

  initial begin
    ctrl_reset = 1'b0;
    {reg17, reg18, reg19, reg20, reg21, reg22, reg23, reg24, reg25, reg26} = '0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data0 = 32'h0;
    rsp_data1 = 32'h0;
    rsp_error = 1'b0;
    tick();
    tick();
    check_eq("rst_reg27", reg27, 32'h0);
    check_eq("rst_reg28", reg28, 32'h0);
    check_eq("rst_reg29", reg29, 32'h0);
    check_eq("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check_eq("rst_rsp_ready", {31'h0, rsp_ready}, 32'h0);
    ctrl_reset = 1'b1;
    tick();

    // Basic two-argument command, engine always ready.
    reg26 = 32'h0105_0002; reg17 = 32'hA; reg18 = 32'hB;
    exp_data[0] = 32'h0105_0002; exp_data[1] = 32'hA; exp_data[2] = 32'hB;
    collect(3, 8'hFF);
    respond(32'h11, 32'h22, 1'b0);
    check_eq("t1_reg27", reg27, 32'h0105_0000);
    check_eq("t1_reg28", reg28, 32'h11);
    check_eq("t1_reg29", reg29, 32'h22);
    check_eq("t1_rsp_ready", {31'h0, rsp_ready}, 32'h0);

    // A response outside WAIT is ignored.
    rsp_valid = 1'b1; rsp_data0 = 32'hDEAD; rsp_data1 = 32'hBEEF;
    tick();
    rsp_valid = 1'b0;
    check_eq("idle_rsp_reg28", reg28, 32'h11);
    check_eq("idle_rsp_reg27", reg27, 32'h0105_0000);

    // Stalled beats with ready toggling 1-0-0-1, error response.
    reg26 = 32'h1005_0002; reg17 = 32'hC; reg18 = 32'hD;
    exp_data[0] = 32'h1005_0002; exp_data[1] = 32'hC; exp_data[2] = 32'hD;
    collect(3, 8'b1001_1001);
    respond(32'h33, 32'h44, 1'b1);
    check_eq("t2_reg27", reg27, 32'h1005_0002);
    check_eq("t2_reg28", reg28, 32'h33);

    // seq changes while busy: 0x03 is skipped, 0x04 serviced afterwards.
    reg26 = 32'h0209_0001; reg17 = 32'h55;
    exp_data[0] = 32'h0209_0001; exp_data[1] = 32'h55;
    collect(2, 8'hFF);
    reg26 = 32'h0309_0001;
    tick();
    reg26 = 32'h040A_0001; reg17 = 32'h99;
    tick();
    respond(32'h66, 32'h77, 1'b0);
    check_eq("t4_first_reg27", reg27, 32'h0209_0000);
    check_eq("t4_first_reg28", reg28, 32'h66);
    exp_data[0] = 32'h040A_0001; exp_data[1] = 32'h99;
    collect(2, 8'hFF);
    respond(32'h12, 32'h34, 1'b0);
    check_eq("t4_second_reg27", reg27, 32'h040A_0000);

    // Bad arg_count: no beats, results unchanged.
    reg26 = 32'h0207_000C;
    tick();
    check_eq("bad_reg27", reg27, 32'h0207_0008);
    check_eq("bad_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check_eq("bad_reg28", reg28, 32'h12);
    tick();
    check_eq("bad_reg27_hold", reg27, 32'h0207_0008);
    check_eq("bad_cmd_valid_hold", {31'h0, cmd_valid}, 32'h0);

    // Nine arguments, reset during beat 1, restart from beat 0.
    reg26 = 32'h050B_0009;
    reg17 = 32'h101; reg18 = 32'h102; reg19 = 32'h103; reg20 = 32'h104; reg21 = 32'h105;
    reg22 = 32'h106; reg23 = 32'h107; reg24 = 32'h108; reg25 = 32'h109;
    cmd_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_mid_index", {28'h0, cmd_index}, 32'h1);
    ctrl_reset = 1'b0;
    tick();
    ctrl_reset = 1'b1;
    cmd_ready = 1'b0;
    check_eq("rst_mid_valid", {31'h0, cmd_valid}, 32'h0);
    check_eq("rst_mid_reg27", reg27, 32'h0);
    check_eq("rst_mid_reg28", reg28, 32'h0);
    check_eq("rst_mid_reg29", reg29, 32'h0);
    exp_data[0] = 32'h050B_0009;
    for (int k = 1; k <= 9; k++) exp_data[k] = 32'h100 + k;
    collect(10, 8'hFF);
    respond(32'hAA, 32'hBB, 1'b0);
    check_eq("t5_reg27", reg27, 32'h050B_0000);
    check_eq("t5_reg29", reg29, 32'hBB);

    // No response: timeout after 8 WAIT cycles, or WAIT held forever.
    reg26 = 32'h060C_0001; reg17 = 32'h77;
    exp_data[0] = 32'h060C_0001; exp_data[1] = 32'h77;
    collect(2, 8'hFF);
`ifdef SHARED_REG_MAILBOX_TIMEOUT_EN
    for (int k = 0; k < 7; k++) tick();
    check_eq("to_pre_rsp_ready", {31'h0, rsp_ready}, 32'h1);
    check_eq("to_pre_busy", {31'h0, reg27[0]}, 32'h1);
    tick();
    check_eq("to_reg27", reg27, 32'h060C_0004);
    check_eq("to_reg28", reg28, 32'h0);
    check_eq("to_reg29", reg29, 32'h0);
    check_eq("to_rsp_ready", {31'h0, rsp_ready}, 32'h0);
`else
    for (int k = 0; k < 100; k++) tick();
    check_eq("hold_rsp_ready", {31'h0, rsp_ready}, 32'h1);
    check_eq("hold_busy", {31'h0, reg27[0]}, 32'h1);
    respond(32'h5, 32'h6, 1'b0);
    check_eq("hold_reg27", reg27, 32'h060C_0000);
    check_eq("hold_reg28", reg28, 32'h5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
